// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: NM masters share one slave port.
// The owner keeps the bus for its whole cyc assertion, so bursts stay intact.
// A watchdog turns a slave that never terminates into an err for the owner.
module wb_rr_arbiter #(
    parameter int NM      = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    // master side
    input  logic [NM*AW-1:0]      wbm_adr_i,
    input  logic [NM*DW-1:0]      wbm_dat_i,
    input  logic [NM*(DW/8)-1:0]  wbm_sel_i,
    input  logic [NM-1:0]         wbm_we_i,
    input  logic [NM-1:0]         wbm_cyc_i,
    input  logic [NM-1:0]         wbm_stb_i,
    input  logic [NM*3-1:0]       wbm_cti_i,
    input  logic [NM*2-1:0]       wbm_bte_i,
    output logic [DW-1:0]         wbm_dat_o,
    output logic [NM-1:0]         wbm_ack_o,
    output logic [NM-1:0]         wbm_err_o,
    output logic [NM-1:0]         wbm_rty_o,
    // slave side
    output logic [AW-1:0]         wbs_adr_o,
    output logic [DW-1:0]         wbs_dat_o,
    output logic [DW/8-1:0]       wbs_sel_o,
    output logic                  wbs_we_o,
    output logic                  wbs_cyc_o,
    output logic                  wbs_stb_o,
    output logic [2:0]            wbs_cti_o,
    output logic [1:0]            wbs_bte_o,
    input  logic [DW-1:0]         wbs_dat_i,
    input  logic                  wbs_ack_i,
    input  logic                  wbs_err_i,
    input  logic                  wbs_rty_i,
    // current owner, one-hot, zero when the bus is free
    output logic [NM-1:0]         grant_o
);

    localparam int SW  = DW / 8;
    localparam int PW  = (NM > 1) ? $clog2(NM) : 1;
    localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [PW:0]    NM_W     = (PW + 1)'(NM);
    localparam logic [PW-1:0]  LAST_IDX = PW'(NM - 1);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic           WD_EN    = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    // Per-master views of the packed input buses
    logic [AW-1:0] m_adr [NM];
    logic [DW-1:0] m_dat [NM];
    logic [SW-1:0] m_sel [NM];
    logic [2:0]    m_cti [NM];
    logic [1:0]    m_bte [NM];

    genvar gi;
    generate
        for (gi = 0; gi < NM; gi++) begin : g_unpack
            assign m_adr[gi] = wbm_adr_i[gi*AW +: AW];
            assign m_dat[gi] = wbm_dat_i[gi*DW +: DW];
            assign m_sel[gi] = wbm_sel_i[gi*SW +: SW];
            assign m_cti[gi] = wbm_cti_i[gi*3 +: 3];
            assign m_bte[gi] = wbm_bte_i[gi*2 +: 2];
        end
    endgenerate

    state_t          state_q, state_d;
    logic [NM-1:0]   grant_q, grant_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [WDW-1:0]  wdog_q, wdog_d;
    logic            abort_first_q, abort_first_d;

    logic            req_found;
    logic [PW-1:0]   req_idx;
    logic            cur_cyc;
    logic            cur_stb;
    logic            slave_term;
    logic [PW-1:0]   ptr_after_owner;

    assign grant_o    = grant_q;
    assign wbm_dat_o  = wbs_dat_i;
    assign cur_cyc    = wbm_cyc_i[gidx_q];
    assign cur_stb    = wbm_stb_i[gidx_q];
    assign slave_term = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign ptr_after_owner = (gidx_q == LAST_IDX) ? '0 : gidx_q + PW'(1);

    // Find the first requester at or after the round-robin pointer
    always_comb begin
        logic [PW:0] cand;
        req_found = 1'b0;
        req_idx   = ptr_q;
        cand      = '0;
        for (int i = 0; i < NM; i++) begin
            cand = {1'b0, ptr_q} + (PW + 1)'(i);
            if (cand >= NM_W) begin
                cand = cand - NM_W;
            end
            if (!req_found && wbm_cyc_i[cand[PW-1:0]]) begin
                req_found = 1'b1;
                req_idx   = cand[PW-1:0];
            end
        end
    end

    // Next-state logic: arbitration, ownership release and watchdog
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        ptr_d         = ptr_q;
        wdog_d        = wdog_q;
        abort_first_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                wdog_d = '0;
                if (req_found) begin
                    state_d          = ST_BUSY;
                    gidx_d           = req_idx;
                    grant_d          = '0;
                    grant_d[req_idx] = 1'b1;
                end
            end

            ST_BUSY: begin
                if (!cur_cyc) begin
                    // owner released; a termination this cycle still reaches it
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_after_owner;
                    wdog_d  = '0;
                end else if (cur_stb && !slave_term) begin
                    if (WD_EN && (wdog_q == WD_LIMIT)) begin
                        state_d       = ST_ABORT;
                        wdog_d        = '0;
                        abort_first_d = 1'b1;
                    end else if (WD_EN) begin
                        wdog_d = wdog_q + WDW'(1);
                    end
                end else begin
                    wdog_d = '0;
                end
            end

            ST_ABORT: begin
                wdog_d = '0;
                if (!cur_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_after_owner;
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                wdog_d  = '0;
            end
        endcase
    end

    // Bus routing: owner drives the slave, slave terminations go to the owner only
    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;

        if (state_q == ST_BUSY) begin
            wbs_adr_o         = m_adr[gidx_q];
            wbs_dat_o         = m_dat[gidx_q];
            wbs_sel_o         = m_sel[gidx_q];
            wbs_we_o          = wbm_we_i[gidx_q];
            wbs_cyc_o         = cur_cyc;
            wbs_stb_o         = cur_stb;
            wbs_cti_o         = m_cti[gidx_q];
            wbs_bte_o         = m_bte[gidx_q];
            wbm_ack_o[gidx_q] = wbs_ack_i;
            wbm_err_o[gidx_q] = wbs_err_i;
            wbm_rty_o[gidx_q] = wbs_rty_i;
        end else if (state_q == ST_ABORT && abort_first_q) begin
            // single err pulse for the watchdog; late slave responses are dropped
            wbm_err_o[gidx_q] = 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            gidx_q        <= '0;
            ptr_q         <= '0;
            wdog_q        <= '0;
            abort_first_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            gidx_q        <= gidx_d;
            ptr_q         <= ptr_d;
            wdog_q        <= wdog_d;
            abort_first_q <= abort_first_d;
        end
    end

endmodule
